// File: rtl/uart_echo_bridge_pkg.sv
// Shared constants, state encoding and baud divisor helper for the UART echo bridge.
// Used by uart_echo_bridge; UART_PARITY_EN (see top) enables the PARITY state.
package uart_echo_bridge_pkg;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  // state       | meaning
  // UART_IDLE   | line idle, waiting for start edge / transmit request
  // UART_START  | start bit
  // UART_DATA   | data bits, LSB first
  // UART_PARITY | even parity bit (UART_PARITY_EN builds only)
  // UART_STOP   | stop bit(s)
  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_e;

  // Clamped to 1 so a slow system clock still yields a tick every cycle.
  function automatic int baud_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head word; push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // The head register follows the word that will sit at rd_ptr next cycle.
      if (do_push && (empty || (count == CW'(1) && do_pop)))
        head <= wdata;
      else if (do_pop)
        head <= mem[rd_ptr + 1'b1];
    end
  end

endmodule

// File: rtl/uart_echo_bridge.sv
// Full-duplex UART with 16x oversampling, RX FIFO and echo/manual transmit.
// Optional macro UART_PARITY_EN adds an even-parity bit and the err_par output.
module uart_echo_bridge
  import uart_echo_bridge_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int STOP_B = 1
) (
  input  logic                   src_clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             baud_sel,
  input  logic                   stream,
  input  logic [DATA_W-1:0]      manual_data,
  input  logic                   send,
  input  logic                   rx_in,
  output logic                   tx_out,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   busy_tx,
  output logic                   busy_rx,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err_frame,
`ifdef UART_PARITY_EN
  output logic                   err_par,
`endif
  output logic                   err_ovf
);
  localparam int DIV_9600   = baud_div(CLK_HZ, 9600);
  localparam int DIV_19200  = baud_div(CLK_HZ, 19200);
  localparam int DIV_57600  = baud_div(CLK_HZ, 57600);
  localparam int DIV_115200 = baud_div(CLK_HZ, 115200);
  localparam int DIV_W      = $clog2(DIV_9600 + 1);
  localparam int BW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [3:0]    LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    MID_TICK  = 4'(MID_SAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  logic [1:0]       baud_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic             tick;

  always_comb begin
    div_last = DIV_W'(DIV_9600 - 1);
    case (baud_q)
      BAUD_9600:   div_last = DIV_W'(DIV_9600 - 1);
      BAUD_19200:  div_last = DIV_W'(DIV_19200 - 1);
      BAUD_57600:  div_last = DIV_W'(DIV_57600 - 1);
      BAUD_115200: div_last = DIV_W'(DIV_115200 - 1);
      default:     ;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      baud_q  <= BAUD_9600;
      div_cnt <= '0;
    end else if (!en) begin
      baud_q  <= baud_sel;
      div_cnt <= '0;
    end else if (div_cnt == div_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = en && (div_cnt == div_last);

  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge src_clk) begin
    if (rst) {rx_sync, rx_meta} <= 2'b11;
    else     {rx_sync, rx_meta} <= {rx_meta, rx_in};
  end

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] rx_shift;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (src_clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rx_shift),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (rx_data)
  );

  assign rx_valid = !fifo_empty;

  // ---------------- receiver ----------------
  uart_state_e rx_state;
  uart_state_e rx_next;
  logic [3:0]  rx_scnt;
  logic [BW-1:0] rx_bit;
  logic        rx_bit_end;
  logic        rx_frame_bad;
`ifdef UART_PARITY_EN
  logic        rx_par_bad;
`endif

  assign rx_bit_end = tick && (rx_scnt == LAST_TICK);
  assign busy_rx    = (rx_state != UART_IDLE);

  always_comb begin
    rx_next      = rx_state;
    fifo_push    = 1'b0;
    rx_frame_bad = 1'b0;
    if (!en) begin
      rx_next = UART_IDLE;
    end else begin
      case (rx_state)
        UART_IDLE:  if (tick && !rx_sync) rx_next = UART_START;
        UART_START: if (tick && rx_scnt == MID_TICK) rx_next = rx_sync ? UART_IDLE : UART_DATA;
        UART_DATA:
          if (rx_bit_end && rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_next = UART_PARITY;
`else
            rx_next = UART_STOP;
`endif
          end
`ifdef UART_PARITY_EN
        UART_PARITY: if (rx_bit_end) rx_next = UART_STOP;
`endif
        UART_STOP:
          if (rx_bit_end) begin
            rx_next      = UART_IDLE;
            fifo_push    = rx_sync;
            rx_frame_bad = !rx_sync;
`ifdef UART_PARITY_EN
            if (rx_par_bad) fifo_push = 1'b0;
`endif
          end
        default: rx_next = UART_IDLE;
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      rx_state  <= UART_IDLE;
      rx_scnt   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      err_frame <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == UART_IDLE || !en)
        rx_scnt <= '0;
      else if (tick)
        rx_scnt <= (rx_state == UART_START && rx_scnt == MID_TICK) ? '0 : rx_scnt + 1'b1;
      if (rx_state == UART_START) begin
        rx_bit <= '0;
      end else if (rx_state == UART_DATA && rx_bit_end) begin
        rx_bit   <= rx_bit + 1'b1;
        rx_shift <= {rx_sync, rx_shift[DATA_W-1:1]};
      end
      if (rx_frame_bad) err_frame <= 1'b1;
      if (fifo_push && fifo_full && !fifo_pop) err_ovf <= 1'b1;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge src_clk) begin
    if (rst) begin
      rx_par_bad <= 1'b0;
      err_par    <= 1'b0;
    end else if (rx_state == UART_START) begin
      rx_par_bad <= 1'b0;
    end else if (rx_state == UART_PARITY && rx_bit_end) begin
      rx_par_bad <= (rx_sync != ^rx_shift);
      if (rx_sync != ^rx_shift) err_par <= 1'b1;
    end
  end
`endif

  // ---------------- transmitter ----------------
  uart_state_e       tx_state;
  uart_state_e       tx_next;
  logic [3:0]        tx_scnt;
  logic [BW-1:0]     tx_bit;
  logic              tx_stop;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_word;
  logic              tx_load_manual;
  logic              tx_load_echo;
  logic              tx_bit_end;
`ifdef UART_PARITY_EN
  logic              tx_par;
`endif

  assign tx_bit_end = tick && (tx_scnt == LAST_TICK);
  assign tx_word    = tx_load_manual ? manual_data : rx_data;
  assign busy_tx    = (tx_state != UART_IDLE);
  assign fifo_pop   = tx_load_echo || (stream && rx_valid && rx_ready);

  always_comb begin
    tx_next        = tx_state;
    tx_load_manual = 1'b0;
    tx_load_echo   = 1'b0;
    if (!en) begin
      tx_next = UART_IDLE;
    end else begin
      case (tx_state)
        UART_IDLE:
          if (stream && send) begin
            tx_load_manual = 1'b1;
            tx_next        = UART_START;
          end else if (!stream && rx_valid) begin
            tx_load_echo = 1'b1;
            tx_next      = UART_START;
          end
        UART_START: if (tx_bit_end) tx_next = UART_DATA;
        UART_DATA:
          if (tx_bit_end && tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_next = UART_PARITY;
`else
            tx_next = UART_STOP;
`endif
          end
`ifdef UART_PARITY_EN
        UART_PARITY: if (tx_bit_end) tx_next = UART_STOP;
`endif
        UART_STOP: if (tx_bit_end && tx_stop == 1'(STOP_B - 1)) tx_next = UART_IDLE;
        default:   tx_next = UART_IDLE;
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      tx_state <= UART_IDLE;
      tx_scnt  <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == UART_IDLE) tx_scnt <= '0;
      else if (tick)             tx_scnt <= tx_scnt + 1'b1;
      if (tx_load_manual || tx_load_echo) begin
        tx_shift <= tx_word;
        tx_bit   <= '0;
        tx_stop  <= 1'b0;
      end else if (tx_bit_end) begin
        if (tx_state == UART_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 1'b1;
        end
        if (tx_state == UART_STOP) tx_stop <= tx_stop + 1'b1;
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge src_clk) begin
    if (rst)                                  tx_par <= 1'b0;
    else if (tx_load_manual || tx_load_echo)  tx_par <= ^tx_word;
  end
`endif

  always_comb begin
    tx_out = 1'b1;
    case (tx_state)
      UART_START:  tx_out = 1'b0;
      UART_DATA:   tx_out = tx_shift[0];
`ifdef UART_PARITY_EN
      UART_PARITY: tx_out = tx_par;
`endif
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_uart_echo_bridge.sv
// Directed self-checking bench for uart_echo_bridge with a word scoreboard.
// Honours UART_PARITY_EN when the design is built with it.
module tb_uart_echo_bridge;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = DW + 3;
`else
  localparam int FRAME_BITS = DW + 2;
`endif

  logic          src_clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    baud_sel = 2'b00;
  logic          stream = 1'b0;
  logic [DW-1:0] manual_data = '0;
  logic          send = 1'b0;
  logic          rx_in = 1'b1;
  logic          rx_ready = 1'b0;
  logic          tx_out;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy_tx;
  logic          busy_rx;
  logic [4:0]    fifo_count;
  logic          err_frame;
  logic          err_ovf;
`ifdef UART_PARITY_EN
  logic          err_par;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] rx_exp_q[$];
  logic [DW-1:0] tx_exp_q[$];

  always #5 src_clk = ~src_clk;

  uart_echo_bridge #(
    .CLK_HZ(1_600_000), .DATA_W(DW), .DEPTH(DEPTH), .STOP_B(1)
  ) dut (
    .src_clk     (src_clk),
    .rst         (rst),
    .en          (en),
    .baud_sel    (baud_sel),
    .stream      (stream),
    .manual_data (manual_data),
    .send        (send),
    .rx_in       (rx_in),
    .tx_out      (tx_out),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy_tx     (busy_tx),
    .busy_rx     (busy_rx),
    .fifo_count  (fifo_count),
    .err_frame   (err_frame),
`ifdef UART_PARITY_EN
    .err_par     (err_par),
`endif
    .err_ovf     (err_ovf)
  );

  task automatic step(input int n);
    repeat (n) @(posedge src_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 115200 baud with this clock: one tick per cycle, 16 cycles per bit.
  task automatic rx_frame(input logic [DW-1:0] d, input logic stop_v, input logic par_flip);
    rx_in = 1'b0;
    step(16);
    for (int i = 0; i < DW; i++) begin
      rx_in = d[i];
      step(16);
    end
`ifdef UART_PARITY_EN
    rx_in = (^d) ^ par_flip;
    step(16);
`endif
    rx_in = stop_v;
    step(16);
    rx_in = 1'b1;
    step(4);
  endtask

  task automatic capture_tx(output logic [DW-1:0] word);
    int n;
    n = 0;
    word = '0;
    while (tx_out !== 1'b0 && n < 400) begin
      step(1);
      n++;
    end
    chk("tx_start_seen", tx_out, 1'b0);
    step(8);
    chk("tx_start_mid", tx_out, 1'b0);
    for (int i = 0; i < DW; i++) begin
      step(16);
      word[i] = tx_out;
    end
`ifdef UART_PARITY_EN
    step(16);
    chk("tx_parity", tx_out, ^word);
`endif
    step(16);
    chk("tx_stop", tx_out, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0]              w;
    logic [DW-1:0]              exp_w;
    logic [FRAME_BITS*16-1:0]   samp;
    logic                       exp_bit;

    rst = 1'b1;
    step(3);
    chk("rst_tx_out", tx_out, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_err_frame", err_frame, 1'b0);
    chk("rst_err_ovf", err_ovf, 1'b0);
    chk("rst_rx_data", rx_data, 0);
    rst = 1'b0;
    step(2);

    // Configure 115200 and receive 0xA5 while holding it in the FIFO.
    en = 1'b0;
    baud_sel = 2'b11;
    step(2);
    en = 1'b1;
    stream = 1'b1;
    step(2);
    rx_exp_q.push_back(8'hA5);
    rx_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_rx_valid", rx_valid, 1'b1);
    chk("a5_rx_data", rx_data, rx_exp_q[0]);
    chk("a5_count", fifo_count, 1);

    tx_exp_q.push_back(rx_exp_q.pop_front());
    stream = 1'b0;
    capture_tx(w);
    chk("echo_word", w, tx_exp_q.pop_front());
    chk("echo_count", fifo_count, 0);
    stream = 1'b1;
    step(16);
    chk("echo_done_idle", busy_tx, 1'b0);

    // Manual send of 0x3C, sampled every cycle; second send while busy.
    exp_w = 8'h3C;
    manual_data = exp_w;
    tx_exp_q.push_back(exp_w);
    send = 1'b1;
    step(1);
    send = 1'b0;
    chk("busy_tx_rise", busy_tx, 1'b1);
    for (int k = 0; k < FRAME_BITS * 16; k++) begin
      samp[k] = tx_out;
      send = (k == 4);
      step(1);
    end
    send = 1'b0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      if (b == 0)                    exp_bit = 1'b0;
      else if (b <= DW)              exp_bit = exp_w[b-1];
      else if (b == FRAME_BITS - 1)  exp_bit = 1'b1;
      else                           exp_bit = ^exp_w;
      chk($sformatf("tx_bit%0d", b), 32'(samp[b*16 +: 16]), {16{exp_bit}});
    end
    for (int i = 0; i < DW; i++) w[i] = samp[(i+1)*16 + 8];
    chk("tx_manual_word", w, tx_exp_q.pop_front());
    chk("tx_end_idle", busy_tx, 1'b0);
    step(20);
    chk("send_not_queued", busy_tx, 1'b0);
    chk("send_not_queued_line", tx_out, 1'b1);

    // 17 frames into a 16-deep FIFO with no reader.
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      w = 8'($urandom_range(255));
      if (i < DEPTH) rx_exp_q.push_back(w);
      rx_frame(w, 1'b1, 1'b0);
    end
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_flag", err_ovf, 1'b1);
    chk("ovf_no_frame_err", err_frame, 1'b0);
    rx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("readback%0d", i), rx_data, rx_exp_q.pop_front());
      step(1);
    end
    rx_ready = 1'b0;
    chk("drain_count", fifo_count, 0);
    chk("drain_valid", rx_valid, 1'b0);

    // Short low glitch: start detected, then rejected without error.
    rx_in = 1'b0;
    step(4);
    chk("glitch_busy_rx", busy_rx, 1'b1);
    rx_in = 1'b1;
    step(24);
    chk("glitch_idle", busy_rx, 1'b0);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_no_err", err_frame, 1'b0);

    // Low stop bit.
    rx_frame(8'h55, 1'b0, 1'b0);
    step(24);
    chk("frame_err", err_frame, 1'b1);
    chk("frame_err_count", fifo_count, 0);

    // Keep one word in the FIFO across an en drop during transmit.
    rx_exp_q.push_back(8'h5A);
    rx_frame(8'h5A, 1'b1, 1'b0);
    chk("keep_count", fifo_count, 1);
    manual_data = 8'h00;
    send = 1'b1;
    step(1);
    send = 1'b0;
    step(38);
    chk("mid_tx_low", tx_out, 1'b0);
    chk("mid_tx_busy", busy_tx, 1'b1);
    en = 1'b0;
    step(1);
    chk("en_drop_line", tx_out, 1'b1);
    chk("en_drop_busy", busy_tx, 1'b0);
    chk("en_drop_count", fifo_count, 1);
    chk("en_drop_head", rx_data, rx_exp_q.pop_front());
    en = 1'b1;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("en_drop_drained", fifo_count, 0);

`ifdef UART_PARITY_EN
    rx_frame(8'h01, 1'b1, 1'b1);
    step(4);
    chk("par_err", err_par, 1'b1);
    chk("par_no_push", fifo_count, 0);
`endif

    // Reset in the middle of activity.
    rx_exp_q.push_back(8'h81);
    rx_frame(8'h81, 1'b1, 1'b0);
    manual_data = 8'hC3;
    send = 1'b1;
    step(1);
    send = 1'b0;
    rx_in = 1'b0;
    step(20);
    rst = 1'b1;
    step(1);
    rx_in = 1'b1;
    chk("rst_mid_line", tx_out, 1'b1);
    chk("rst_mid_busy_tx", busy_tx, 1'b0);
    chk("rst_mid_busy_rx", busy_rx, 1'b0);
    chk("rst_mid_count", fifo_count, 0);
    chk("rst_mid_valid", rx_valid, 1'b0);
    chk("rst_mid_err_ovf", err_ovf, 1'b0);
    chk("rst_mid_err_frame", err_frame, 1'b0);
    rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
